// File: rtl/reg_hazard_scoreboard.sv
// Scoreboard that sits next to the ID stage and tracks in-flight destinations.
// It decides the ID stall, the per-source forward selects and a saturating stall counter.
module reg_hazard_scoreboard #(
    parameter int REG_W           = 6,
    parameter int DEPTH           = 3,
    parameter int LOAD_READY_SLOT = 1,
    parameter int FWD_EN          = 1,
    parameter int CNT_W           = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [REG_W-1:0]             id_src1,
    input  logic [REG_W-1:0]             id_src2,
    input  logic [REG_W-1:0]             id_dst,
    input  logic                         id_is_load,
    input  logic                         pipe_hold,
    input  logic                         flush,
    output logic                         stall,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_sel1,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_sel2,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam int SEL_W = $clog2(DEPTH+1);

    // Slot 0 is EX (youngest); slot DEPTH-1 is WB.
    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] slot_load;
    logic [REG_W-1:0] slot_dst [DEPTH];

    logic [SEL_W:0] look1;
    logic [SEL_W:0] look2;
    logic           stall_src1;
    logic           stall_src2;

    // Returns {stall, sel}. Scanning oldest to youngest lets the youngest hit win.
    function automatic logic [SEL_W:0] lookup(input logic [REG_W-1:0] src);
        logic [SEL_W:0] r;
        logic           blk;
        r = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (slot_valid[k] && (slot_dst[k] == src) && (src != '0)) begin
                blk = (FWD_EN == 0) || (slot_load[k] && (k < LOAD_READY_SLOT));
                r   = {blk, SEL_W'(k + 1)};
            end
        end
        return r;
    endfunction

    always_comb begin
        look1      = lookup(id_src1);
        look2      = lookup(id_src2);
        stall_src1 = look1[SEL_W];
        stall_src2 = look2[SEL_W];
        fwd_sel1   = look1[SEL_W-1:0];
        fwd_sel2   = look2[SEL_W-1:0];
        stall      = id_valid & ~flush & (stall_src1 | stall_src2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            slot_load  <= '0;
            for (int k = 0; k < DEPTH; k++) slot_dst[k] <= '0;
            stall_cnt  <= '0;
        end else if (!pipe_hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_load[k]  <= slot_load[k-1];
                slot_dst[k]   <= slot_dst[k-1];
            end
            // A stalled or flushed instruction leaves a bubble behind it.
            slot_valid[0] <= id_valid & ~stall & ~flush & (id_dst != '0);
            slot_dst[0]   <= id_dst;
            slot_load[0]  <= id_is_load;
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/reg_hazard_scoreboard.md
Name: reg_hazard_scoreboard

Overview:
- Parametrised hazard and forwarding scoreboard for the MIPS pipeline.
- Sits beside the ID stage and consumes the decoded source/destination register IDs: 6-bit space, 0-31 GPR, 33 HI/LO, 2/4 syscall aliases, 0 = none.
- Tracks in-flight destinations across DEPTH downstream stages; emits ID stall, per-source forward selects and a saturating stall counter.
- Adds a no-forwarding mode and load-latency awareness to plain register selection.

Parameters:
- REG_W, 6: width of register IDs.
- DEPTH, 3: tracked slots after ID. Slot 0 = EX (youngest) ... slot DEPTH-1 = WB.
- LOAD_READY_SLOT, 1: lowest slot from which a load result is forwardable.
- FWD_EN, 1: 1 = forward when legal; 0 = any RAW hit stalls.
- CNT_W, 32: stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  REG_W  first source ID. 0 = unused.
- id_src2  in  REG_W  second source ID. 0 = unused.
- id_dst  in  REG_W  destination ID. 0 = no write.
- id_is_load  in  1  ID instruction is a load.
- pipe_hold  in  1  global freeze (memory wait); scoreboard state unchanged.
- flush  in  1  kill ID instruction (branch/exception).
- stall  out  1  hold PC/IF/ID, insert bubble into EX.
- fwd_sel1  out  $clog2(DEPTH+1)  0 = register file; k+1 = forward from slot k.
- fwd_sel2  out  $clog2(DEPTH+1)  same, for src2.
- stall_cnt  out  CNT_W  count of stall cycles, saturating.

Behaviour:
- State: per slot, valid, dst[REG_W] and is_load. Plus stall_cnt.
- Reset (rst=1 at edge): all slot valid=0, dst=0, is_load=0, stall_cnt=0. Outputs then read stall=0, fwd_sel1=fwd_sel2=0.
- rst has priority over pipe_hold and flush.
- Match, per source s in {src1, src2}:
  - hit(k) = slot[k].valid & slot[k].dst==s & s!=0.
  - Choose the youngest k with a hit (lowest index) only. Older hits are ignored.
- Per-source stall:
  - With a hit at k, stall if FWD_EN==0, or if slot[k].is_load and k < LOAD_READY_SLOT.
  - Otherwise fwd_sel = k+1.
  - No hit: fwd_sel = 0, no stall.
- stall = id_valid & ~flush & (stall_src1 | stall_src2).
- stall, fwd_sel1 and fwd_sel2 are combinational from slot state and ID inputs, with zero latency.
- When stall=1, fwd_sel outputs still reflect the youngest hit, but are don't-care for consumers.
- Advance when pipe_hold=0 at the clock edge:
  - slot[k] <= slot[k-1] for k=1..DEPTH-1; slot DEPTH-1 retires.
  - slot[0] <= {id_valid & ~stall & ~flush & (id_dst!=0), id_dst, id_is_load}.
  - On stall or flush, slot[0] becomes a bubble (valid=0).
- pipe_hold=1: all slots and stall_cnt hold, and stall_cnt does not increment.
- stall output is still computed while pipe_hold=1.
- stall_cnt increments by 1 on each edge with stall=1 & pipe_hold=0 & rst=0. It saturates at all-ones.
- Simultaneous cases:
  - flush with a hazard: stall=0 and a bubble is inserted.
  - Same dst in multiple slots: youngest wins.
  - Same src1==src2: both selects are identical.
- ID 0 never matches. A write to ID 0 never occupies a valid slot.
- rst mid-stall clears all slots, so the stall drops the next cycle.

Test Plan:
- Reset, then ADDU dst=8 into slot 0; next ID src1=8 -> stall=0, fwd_sel1=1. One cycle later (slot 1) -> fwd_sel1=2.
- LW dst=9 in slot 0, ID src2=9 -> stall=1 for exactly one cycle, stall_cnt 0->1. Next cycle load in slot 1 -> stall=0, fwd_sel2=2.
- dst=5 in slot 0 and slot 2, ID src1=5 -> fwd_sel1=1 (youngest). Src1=0 with slot 0 dst=0 write -> no hit, fwd_sel1=0.
- FWD_EN=0, ADD dst=3 then ID src1=3 -> stall=1 for 3 cycles until retire, stall_cnt=3.
- Load-use hazard with flush=1 -> stall=0, slot 0 bubble. pipe_hold=1 during a stall -> slots frozen, stall_cnt unchanged.
- CNT_W=2, force 5 stall cycles -> stall_cnt saturates at 3. rst asserted -> stall_cnt=0, all fwd_sel=0 next cycle.
